delta_conv_stream_unit: RTL



---
 rtl/delta_conv_stream_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/delta_conv_stream_unit.sv
// delta_conv_stream_unit: streaming KxK convolution with unary (temporal) multiply-accumulate.
// Row partial sums ripple across the accumulator window and down the rows through the line buffer.
module delta_conv_stream_unit #(
    parameter  int DATA_W   = 8,
    parameter  int WEIGHT_W = 8,
    parameter  int ACC_W    = 24,
    parameter  int K        = 3,
    parameter  int IN_W     = 32,
    parameter  int IN_H     = 32,
    localparam int WA       = $clog2(K * K),
    localparam int RW       = $clog2(IN_H),
    localparam int CW       = $clog2(IN_W)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       stride2,
    input  logic                       weight_wr_en,
    input  logic [WA-1:0]              weight_wr_addr,
    input  logic signed [WEIGHT_W-1:0] weight_wr_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    output logic [RW-1:0]              out_row,
    output logic [CW-1:0]              out_col,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);
    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_INPUT, LOAD, ACCUM, STORE, OUT, DONE} state_t;

    localparam logic [RW-1:0] R_MAX = RW'(IN_H - 1);
    localparam logic [RW-1:0] RK    = RW'(K - 1);
    localparam logic [RW-1:0] RL2   = RW'((IN_H - K) / 2 * 2 + K - 1);
    localparam logic [CW-1:0] C_MAX = CW'(IN_W - 1);
    localparam logic [CW-1:0] CK    = CW'(K - 1);
    localparam logic [CW-1:0] CL2   = CW'((IN_W - K) / 2 * 2 + K - 1);
    localparam logic          KP    = 1'((K - 1) % 2);

    state_t                     state, nxt;
    logic                       s2;
    logic [RW-1:0]              r;
    logic [CW-1:0]              c;
    logic [DATA_W-1:0]          cnt;
    logic signed [WEIGHT_W-1:0] wf  [K*K];
    logic signed [ACC_W-1:0]    acc [K][K];
    logic signed [ACC_W-1:0]    lb  [K-1][IN_W];
    logic                       emit, last_px, adv;

    // stride 2 keeps windows whose top-left row/col offsets are even, i.e. r, c share parity with K-1
    assign emit    = r >= RK && c >= CK && (!s2 || (r[0] == KP && c[0] == KP));
    assign last_px = r == R_MAX && c == C_MAX;
    assign adv     = (state == STORE && !emit) || (state == OUT && out_ready);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = start ? CLEAR : IDLE;
            CLEAR:      nxt = WAIT_INPUT;
            WAIT_INPUT: nxt = in_valid ? LOAD : WAIT_INPUT;
            LOAD:       nxt = cnt != '0 ? ACCUM : STORE;
            ACCUM:      nxt = cnt == DATA_W'(1) ? STORE : ACCUM;
            STORE:      nxt = emit ? OUT : last_px ? DONE : WAIT_INPUT;
            OUT:        nxt = !out_ready ? OUT : last_px ? DONE : WAIT_INPUT;
            DONE:       nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == WAIT_INPUT;
        out_valid = state == OUT;
        busy      = state != IDLE;
        done      = state == DONE;
        out_data  = out_valid ? acc[K-1][K-1] : '0;
        out_row   = out_valid ? r - RK : '0;
        out_col   = out_valid ? c - CK : '0;
        out_last  = out_valid && r == (s2 ? RL2 : R_MAX) && c == (s2 ? CL2 : C_MAX);
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            s2  <= 1'b0;
            r   <= '0;
            c   <= '0;
            cnt <= '0;
            wf  <= '{default: '0};
            acc <= '{default: '0};
            lb  <= '{default: '0};
        end else begin
            if (state == IDLE && start) s2 <= stride2;
            if (state == IDLE && weight_wr_en && 32'(weight_wr_addr) < K * K)
                wf[weight_wr_addr] <= weight_wr_data;
            if (state == CLEAR) begin
                acc <= '{default: '0};
                lb  <= '{default: '0};
                r   <= '0;
                c   <= '0;
            end
            if (state == WAIT_INPUT && in_valid) cnt <= in_data;
            if (state == LOAD) begin
                acc[0][0] <= '0;
                for (int i = 1; i < K; i++) acc[i][0] <= lb[i-1][c];
                for (int i = 0; i < K; i++)
                    for (int j = 1; j < K; j++) acc[i][j] <= acc[i][j-1];
            end
            if (state == ACCUM) begin
                cnt <= cnt - DATA_W'(1);
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++) acc[i][j] <= acc[i][j] + ACC_W'(wf[i*K+j]);
            end
            if (state == STORE && c >= CK)
                for (int i = 0; i < K - 1; i++) lb[i][c - CK] <= acc[i][K-1];
            if (adv) begin
                c <= c == C_MAX ? '0 : c + CW'(1);
                if (c == C_MAX) r <= r + RW'(1);
            end
        end
endmodule
